fb_rect_writer: RTL and testbench

Framebuffer writer that fills axis-aligned rectangles of one 12-bit RGB colour into the 640x480 background block RAM through its second (write) port, while the VGA path reads port A. It accepts one command at a time over a valid/ready handshake, clips it to the screen and emits one BRAM write per clock. An optional mode holds the fill until the start of vertical sync to avoid tearing.

---
 rtl/fb_pkg.sv | 25 ++
 rtl/fb_rect_writer_if.sv | 30 +++
 rtl/fb_addr_gen.sv | 91 +++++++++
 rtl/fb_rect_writer.sv | 129 ++++++++++++
 tb/tb_fb_rect_writer.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared types and default geometry for the framebuffer rectangle writer.
package fb_pkg;

    localparam int FB_H_RES  = 640;
    localparam int FB_V_RES  = 480;
    localparam int FB_ADDR_W = 19;

    typedef logic [11:0] rgb444_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        FILL    = 2'd2,
        DONE    = 2'd3
    } fill_state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [9:0] w;
        logic [9:0] h;
        rgb444_t    color;
    } rect_cmd_t;

endpackage

// File: rtl/fb_rect_writer_if.sv
// Command handshake and BRAM port B write bus of the rectangle writer.
interface fb_rect_writer_if
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [9:0]        cmd_x;
    logic [9:0]        cmd_y;
    logic [9:0]        cmd_w;
    logic [9:0]        cmd_h;
    rgb444_t           cmd_color;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] fb_addr;
    rgb444_t           fb_din;
    logic              fb_we;

    modport master (
        output cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        input  cmd_ready, busy, done, fb_addr, fb_din, fb_we
    );

    modport slave (
        input  cmd_valid, cmd_x, cmd_y, cmd_w, cmd_h, cmd_color,
        output cmd_ready, busy, done, fb_addr, fb_din, fb_we
    );

endinterface

// File: rtl/fb_addr_gen.sv
// Row/column scan of a clipped rectangle; address = row_base + col with no
// multiplier in the pixel loop.
module fb_addr_gen
    import fb_pkg::*;
#(
    parameter int H_RES  = FB_H_RES,
    parameter int ADDR_W = FB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [9:0]        x_start,
    input  logic [9:0]        y_start,
    input  logic [10:0]       x_end,
    input  logic [10:0]       y_end,
    input  logic              advance,
    output logic [ADDR_W-1:0] addr,
    output logic              last_pixel
);

    logic [10:0]       col_q, col_d;
    logic [10:0]       row_q, row_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [9:0]        xs_q, xs_d;
    logic [10:0]       xe_q, xe_d;
    logic [10:0]       ye_q, ye_d;
    logic [ADDR_W-1:0] base_init;
    logic              col_last;
    logic              row_last;

    // Starting row base as a constant shift-add of y (640 -> y<<9 + y<<7).
    always_comb begin
        base_init = '0;
        for (int i = 0; i < 11; i++) begin
            if (H_RES[i]) begin
                base_init = base_init + (ADDR_W'(y_start) << i);
            end
        end
    end

    // Next counter values: load a new rectangle or step one pixel.
    always_comb begin
        col_d      = col_q;
        row_d      = row_q;
        row_base_d = row_base_q;
        xs_d       = xs_q;
        xe_d       = xe_q;
        ye_d       = ye_q;
        col_last   = (col_q == xe_q - 11'd1);
        row_last   = (row_q == ye_q - 11'd1);
        if (load) begin
            xs_d       = x_start;
            xe_d       = x_end;
            ye_d       = y_end;
            col_d      = {1'b0, x_start};
            row_d      = {1'b0, y_start};
            row_base_d = base_init;
        end else if (advance) begin
            if (col_last) begin
                col_d      = {1'b0, xs_q};
                row_d      = row_q + 11'd1;
                row_base_d = row_base_q + ADDR_W'(H_RES);
            end else begin
                col_d = col_q + 11'd1;
            end
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            row_base_q <= '0;
            xs_q       <= '0;
            xe_q       <= '0;
            ye_q       <= '0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            row_base_q <= row_base_d;
            xs_q       <= xs_d;
            xe_q       <= xe_d;
            ye_q       <= ye_d;
        end
    end

    assign addr       = row_base_q + ADDR_W'(col_q);
    assign last_pixel = col_last && row_last;

endmodule

// File: rtl/fb_rect_writer.sv
// Fills clipped rectangles of one colour into the framebuffer, one BRAM
// write per clock, optionally deferred to the next vsync falling edge.
//
// state   | meaning
// IDLE    | cmd_ready high, waiting for a command
// WAIT_VS | command latched, holding until vs_in falls
// FILL    | scanning the clipped rectangle, one pixel per cycle
// DONE    | command finished; done pulses from this state
module fb_rect_writer
    import fb_pkg::*;
#(
    parameter int H_RES      = FB_H_RES,
    parameter int V_RES      = FB_V_RES,
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int WAIT_VSYNC = 0
) (
    input  logic            pixel_clk,
    input  logic            CPU_RESETN,
    input  logic            vs_in,
    fb_rect_writer_if.slave bus
);

    fill_state_t       state_q, state_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              fb_we_q, fb_we_d;
    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    rgb444_t           fb_din_q, fb_din_d;
    logic              vs_prev_q, vs_prev_d;

    rect_cmd_t         cmd_in;
    logic [10:0]       x_sum, y_sum, x_end, y_end;
    logic              cmd_empty;
    logic              accept;
    logic              vs_fall;
    logic [ADDR_W-1:0] gen_addr;
    logic              gen_last;

    // Clip the incoming command against the screen with 11-bit sums.
    always_comb begin
        cmd_in.x     = bus.cmd_x;
        cmd_in.y     = bus.cmd_y;
        cmd_in.w     = bus.cmd_w;
        cmd_in.h     = bus.cmd_h;
        cmd_in.color = bus.cmd_color;
        x_sum        = {1'b0, cmd_in.x} + {1'b0, cmd_in.w};
        y_sum        = {1'b0, cmd_in.y} + {1'b0, cmd_in.h};
        x_end        = (x_sum > 11'(H_RES)) ? 11'(H_RES) : x_sum;
        y_end        = (y_sum > 11'(V_RES)) ? 11'(V_RES) : y_sum;
        cmd_empty    = (cmd_in.w == 10'd0) || (cmd_in.h == 10'd0) ||
                       ({1'b0, cmd_in.x} >= 11'(H_RES)) ||
                       ({1'b0, cmd_in.y} >= 11'(V_RES));
        accept       = bus.cmd_valid && cmd_ready_q;
        vs_fall      = vs_prev_q && !vs_in;
    end

    // Next state and registered outputs; outputs lag the state by one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (cmd_empty)            state_d = DONE;
                    else if (WAIT_VSYNC != 0) state_d = WAIT_VS;
                    else                      state_d = FILL;
                end
            end
            WAIT_VS: if (vs_fall)  state_d = FILL;
            FILL:    if (gen_last) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        cmd_ready_d = (state_q == IDLE) && !accept;
        busy_d      = (state_q != IDLE);
        done_d      = (state_q == DONE);
        fb_we_d     = (state_q == FILL);
        fb_addr_d   = (state_q == FILL) ? gen_addr : fb_addr_q;
        fb_din_d    = accept ? cmd_in.color : fb_din_q;
        vs_prev_d   = vs_in;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge pixel_clk) begin
        if (!CPU_RESETN) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_din_q    <= '0;
            vs_prev_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fb_we_q     <= fb_we_d;
            fb_addr_q   <= fb_addr_d;
            fb_din_q    <= fb_din_d;
            vs_prev_q   <= vs_prev_d;
        end
    end

    fb_addr_gen #(
        .H_RES  (H_RES),
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk        (pixel_clk),
        .rst_n      (CPU_RESETN),
        .load       (accept),
        .x_start    (cmd_in.x),
        .y_start    (cmd_in.y),
        .x_end      (x_end),
        .y_end      (y_end),
        .advance    (state_q == FILL),
        .addr       (gen_addr),
        .last_pixel (gen_last)
    );

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.fb_we     = fb_we_q;
    assign bus.fb_addr   = fb_addr_q;
    assign bus.fb_din    = fb_din_q;

endmodule

// File: tb/tb_fb_rect_writer.sv
// Directed and randomized checks of fb_rect_writer against a pixel-list model.
module tb_fb_rect_writer;

    localparam int HR = 640;
    localparam int VR = 480;

    logic clk = 1'b0;
    logic rst_n;
    logic vs0, vs1;
    int   checks = 0;
    int   errors = 0;
    int unsigned exp_q[$];

    always #5 clk = ~clk;

    fb_rect_writer_if #(.ADDR_W(19)) bus0 ();
    fb_rect_writer_if #(.ADDR_W(19)) bus1 ();

    fb_rect_writer #(.WAIT_VSYNC(0)) dut0 (
        .pixel_clk (clk), .CPU_RESETN (rst_n), .vs_in (vs0), .bus (bus0)
    );
    fb_rect_writer #(.WAIT_VSYNC(1)) dut1 (
        .pixel_clk (clk), .CPU_RESETN (rst_n), .vs_in (vs1), .bus (bus1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected write addresses: every on-screen pixel of the rectangle, row-major.
    function automatic void build_model(input int x, input int y, input int w, input int h);
        int xe, ye;
        exp_q.delete();
        xe = (x + w < HR) ? x + w : HR;
        ye = (y + h < VR) ? y + h : VR;
        for (int yy = y; yy < ye; yy++)
            for (int xx = x; xx < xe; xx++)
                exp_q.push_back(yy * HR + xx);
    endfunction

    // No write may ever land outside the framebuffer.
    always @(negedge clk) begin
        if (bus0.fb_we) begin
            checks++;
            assert (bus0.fb_addr < 19'd307200) else begin
                errors++;
                $error("FAIL addr_range: observed %0d expected <307200", bus0.fb_addr);
            end
        end
    end

    // Present a command on bus0 and return in the cycle after it is accepted.
    task automatic send0(input int x, input int y, input int w, input int h,
                         input int c, input bit keep);
        int t = 0;
        bus0.cmd_x = 10'(x); bus0.cmd_y = 10'(y);
        bus0.cmd_w = 10'(w); bus0.cmd_h = 10'(h);
        bus0.cmd_color = 12'(c);
        bus0.cmd_valid = 1'b1;
        while (!bus0.cmd_ready && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check("accept_timeout", 32'(bus0.cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        if (!keep) bus0.cmd_valid = 1'b0;
    endtask

    // From the cycle after acceptance, check the whole write burst and completion.
    task automatic expect0(input int x, input int y, input int w, input int h, input int c);
        build_model(x, y, w, h);
        check("ready_after_accept", 32'(bus0.cmd_ready), 32'd0);
        check("busy_accept_cycle", 32'(bus0.busy), 32'd0);
        check("we_accept_cycle", 32'(bus0.fb_we), 32'd0);
        foreach (exp_q[k]) begin
            @(negedge clk);
            check("we", 32'(bus0.fb_we), 32'd1);
            check("addr", 32'(bus0.fb_addr), exp_q[k]);
            check("din", 32'(bus0.fb_din), 32'(c));
            check("done_early", 32'(bus0.done), 32'd0);
            check("busy_fill", 32'(bus0.busy), 32'd1);
        end
        @(negedge clk);
        check("done_pulse", 32'(bus0.done), 32'd1);
        check("we_after_last", 32'(bus0.fb_we), 32'd0);
        check("busy_done", 32'(bus0.busy), 32'd1);
        check("ready_done", 32'(bus0.cmd_ready), 32'd0);
        @(negedge clk);
        check("done_one_cycle", 32'(bus0.done), 32'd0);
        check("busy_cleared", 32'(bus0.busy), 32'd0);
        check("ready_back", 32'(bus0.cmd_ready), 32'd1);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int wcount;
        bit seen;
        int rx, ry, rw, rh, rc;

        rst_n = 1'b0; vs0 = 1'b1; vs1 = 1'b1;
        bus0.cmd_valid = 1'b0; bus0.cmd_x = '0; bus0.cmd_y = '0;
        bus0.cmd_w = '0; bus0.cmd_h = '0; bus0.cmd_color = '0;
        bus1.cmd_valid = 1'b0; bus1.cmd_x = '0; bus1.cmd_y = '0;
        bus1.cmd_w = '0; bus1.cmd_h = '0; bus1.cmd_color = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(bus0.cmd_ready), 32'd1);
        check("rst_busy", 32'(bus0.busy), 32'd0);
        check("rst_done", 32'(bus0.done), 32'd0);
        check("rst_we", 32'(bus0.fb_we), 32'd0);
        check("rst_addr", 32'(bus0.fb_addr), 32'd0);
        check("rst_din", 32'(bus0.fb_din), 32'd0);
        check("rst_ready1", 32'(bus1.cmd_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic fill.
        send0(10, 2, 3, 2, 12'hF00, 1'b0);
        expect0(10, 2, 3, 2, 12'hF00);

        // Clip at the bottom-right corner.
        send0(638, 479, 5, 4, 12'h0F0, 1'b0);
        expect0(638, 479, 5, 4, 12'h0F0);

        // Empty commands.
        send0(100, 100, 0, 5, 12'h00F, 1'b0);
        expect0(100, 100, 0, 5, 12'h00F);
        send0(640, 10, 5, 5, 12'h123, 1'b0);
        expect0(640, 10, 5, 5, 12'h123);
        send0(5, 480, 5, 5, 12'h456, 1'b0);
        expect0(5, 480, 5, 5, 12'h456);
        send0(0, 0, 1, 1, 12'hFFF, 1'b0);
        expect0(0, 0, 1, 1, 12'hFFF);

        // Back-to-back: second command held valid while busy.
        send0(20, 30, 4, 3, 12'hA5A, 1'b1);
        bus0.cmd_x = 10'd630; bus0.cmd_y = 10'd31;
        bus0.cmd_w = 10'd20;  bus0.cmd_h = 10'd2;
        bus0.cmd_color = 12'h5A5;
        expect0(20, 30, 4, 3, 12'hA5A);
        @(posedge clk);
        @(negedge clk);
        bus0.cmd_valid = 1'b0;
        expect0(630, 31, 20, 2, 12'h5A5);

        // Randomized rectangles, biased toward the screen edges.
        for (int i = 0; i < 16; i++) begin
            rx = (i % 2 == 0) ? int'($urandom_range(0, 700)) : int'($urandom_range(600, 660));
            ry = (i % 3 == 0) ? int'($urandom_range(0, 500)) : int'($urandom_range(470, 490));
            rw = int'($urandom_range(0, 40));
            rh = int'($urandom_range(0, 8));
            rc = int'($urandom_range(0, 4095));
            send0(rx, ry, rw, rh, rc, 1'b0);
            expect0(rx, ry, rw, rh, rc);
        end

        // Vsync-gated instance: a low vs_in at acceptance is not an edge.
        vs1 = 1'b0;
        bus1.cmd_x = 10'd5; bus1.cmd_y = 10'd3; bus1.cmd_w = 10'd2; bus1.cmd_h = 10'd1;
        bus1.cmd_color = 12'hABC; bus1.cmd_valid = 1'b1;
        check("vs_ready", 32'(bus1.cmd_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus1.cmd_valid = 1'b0;
        wcount = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus1.fb_we) wcount++;
        end
        vs1 = 1'b1;
        repeat (100) begin
            @(negedge clk);
            if (bus1.fb_we) wcount++;
        end
        check("vs_hold_no_write", 32'(wcount), 32'd0);
        check("vs_hold_busy", 32'(bus1.busy), 32'd1);
        vs1 = 1'b0;
        @(negedge clk);
        check("vs_we_1cyc", 32'(bus1.fb_we), 32'd0);
        @(negedge clk);
        check("vs_we_2cyc", 32'(bus1.fb_we), 32'd1);
        check("vs_addr0", 32'(bus1.fb_addr), 32'(3 * HR + 5));
        check("vs_din", 32'(bus1.fb_din), 32'hABC);
        @(negedge clk);
        check("vs_addr1", 32'(bus1.fb_addr), 32'(3 * HR + 6));
        @(negedge clk);
        check("vs_done", 32'(bus1.done), 32'd1);
        check("vs_we_end", 32'(bus1.fb_we), 32'd0);
        vs1 = 1'b1;

        // Reset in the middle of a full-screen fill.
        send0(0, 0, 640, 480, 12'h777, 1'b0);
        wcount = 0;
        for (int k = 0; k < 200 && wcount < 50; k++) begin
            @(negedge clk);
            if (bus0.fb_we) begin
                check("full_addr", 32'(bus0.fb_addr), 32'(wcount));
                wcount++;
            end
        end
        check("full_count", 32'(wcount), 32'd50);
        rst_n = 1'b0;
        @(negedge clk);
        check("rst_mid_we", 32'(bus0.fb_we), 32'd0);
        check("rst_mid_busy", 32'(bus0.busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (bus0.done || bus0.fb_we) seen = 1'b1;
        end
        check("rst_no_done", 32'(seen), 32'd0);
        check("rst_ready_after", 32'(bus0.cmd_ready), 32'd1);

        // The writer still works after the abort.
        send0(3, 4, 2, 2, 12'h0AB, 1'b0);
        expect0(3, 4, 2, 2, 12'h0AB);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
